// File: rtl/mips_divider_pkg.sv
// ----------------------------------------------------------------------------
// mips_divider_pkg
// Shared definitions for the multi-cycle MIPS div/divu unit: default operand
// width, FSM state encodings and the iteration-counter width helper.
// ----------------------------------------------------------------------------
package mips_divider_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_SIGN = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // One extra bit so the counter can represent WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int CNT_W = cnt_width(WIDTH);

endpackage

// File: rtl/mips_divider_div_step.sv
// ----------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration.
//   rem_in       : partial remainder before the step (WIDTH+1 bits)
//   dividend_bit : next dividend bit shifted into the remainder
//   divisor      : divisor magnitude
//   rem_out      : partial remainder after the step
//   q_bit        : quotient bit produced by the step
// ----------------------------------------------------------------------------
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] divisor_n;
  logic [WIDTH:0] diff;
  // A restored partial remainder is always below the divisor, so its top bit
  // is zero entering a step and drops out of the shift.
  logic           unused_rem_msb;

  assign unused_rem_msb = rem_in[WIDTH];
  assign shifted        = {rem_in[WIDTH-1:0], dividend_bit};

  // Trial subtraction as shifted + ~divisor + 1 in WIDTH+1 bits.
  assign divisor_n = ~{1'b0, divisor};
  assign diff      = shifted + divisor_n + {{WIDTH{1'b0}}, 1'b1};

  assign q_bit   = ~diff[WIDTH];
  assign rem_out = q_bit ? diff : shifted;

endmodule

// File: rtl/mips_divider.sv
// ----------------------------------------------------------------------------
// mips_divider
// Multi-cycle radix-2 restoring divider for MIPS div/divu. One quotient bit
// per clock; results go to LO (quotient) and HI (remainder).
//   clk, reset   : clock, synchronous active-high reset
//   start        : one-cycle request, honoured in IDLE or DONE only
//   is_signed    : 1 = div, 0 = divu (sampled with start)
//   dividend     : rs operand (sampled with start)
//   divisor      : rt operand (sampled with start)
//   busy         : high in CALC and SIGN
//   done         : one-cycle result-valid pulse
//   quotient     : LO result, holds last value
//   remainder    : HI result, holds last value
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start
// CALC  | WIDTH restoring iterations, one per clock
// SIGN  | apply result signs, load output registers
// DONE  | done pulse; a start here launches the next division directly
// ----------------------------------------------------------------------------
module mips_divider
  import mips_divider_pkg::*;
#(
  parameter int WIDTH = mips_divider_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int              CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  // Holds the dividend magnitude; quotient bits shift in from the bottom as
  // dividend bits leave the top, so it ends up holding the raw quotient.
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   step_rem;
  logic             step_q;

  assign dvd_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign dvs_mag = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in       (rem_q),
    .dividend_bit (dvd_q[WIDTH-1]),
    .divisor      (dvs_q),
    .rem_out      (step_rem),
    .q_bit        (step_q)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_CALC;
          dvd_d   = dvd_mag;
          dvs_d   = dvs_mag;
          // Divide-by-zero leaves the all-ones quotient unsigned so the
          // result is 0xFFFFFFFF in both modes.
          q_neg_d = is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1])
                    && (divisor != '0);
          r_neg_d = is_signed && dividend[WIDTH-1];
          rem_d   = '0;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) state_d = ST_SIGN;
      end
      ST_SIGN: begin
        quotient_d  = q_neg_q ? -dvd_q : dvd_q;
        remainder_d = r_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        state_d     = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign busy      = (state_q == ST_CALC) || (state_q == ST_SIGN);
  assign done      = (state_q == ST_DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule

// File: tb/tb_mips_divider.sv
// ----------------------------------------------------------------------------
// tb_mips_divider
// Self-checking bench for mips_divider: directed cases plus randomized
// divisions against an arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_mips_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] last_q   = '0;
  logic [31:0] last_r   = '0;

  mips_divider #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer division, truncating toward zero; remainder
  // takes the dividend's sign. Divide-by-zero gives all-ones / dividend.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  input logic s,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end
  endfunction

  // Launches a division (start sampled at the next edge = edge 0) and checks
  // latency, busy/done shape and results. ign pulses start at edges 5 and 20;
  // chain leaves the bench in the done cycle so the caller can restart.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input bit ign, input bit chain);
    logic [31:0] eq, er;
    int busy_bad, done_bad;
    ref_div(a, b, s, eq, er);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    is_signed = 1'($urandom_range(0, 1));
    busy_bad  = (busy) ? 0 : 1;
    done_bad  = (done) ? 1 : 0;
    for (int i = 1; i <= 32; i++) begin
      start = ign && (i == 5 || i == 20);
      tick();
      if (!busy) busy_bad++;
      if (done)  done_bad++;
    end
    start = 1'b0;
    check_val("busy_edges_0_32", 32'(busy_bad), 32'd0);
    check_val("done_while_busy", 32'(done_bad), 32'd0);
    check_val("quotient_held_busy", quotient, last_q);
    check_val("remainder_held_busy", remainder, last_r);
    tick();
    check_val("done_edge33", 32'(done), 32'd1);
    check_val("busy_in_done", 32'(busy), 32'd0);
    check_val("quotient", quotient, eq);
    check_val("remainder", remainder, er);
    last_q = eq;
    last_r = er;
    if (!chain) begin
      tick();
      check_val("done_edge34", 32'(done), 32'd0);
      check_val("busy_edge34", 32'(busy), 32'd0);
      check_val("quotient_hold", quotient, eq);
      if (ign) begin
        done_bad = 0;
        repeat (40) begin
          tick();
          if (done || busy) done_bad++;
        end
        check_val("ignored_start_no_second_done", 32'(done_bad), 32'd0);
      end
    end
  endtask

  initial begin
    logic [31:0] a, b;
    logic        s;
    bit          ch;

    reset     = 1'b1;
    start     = 1'b1;
    is_signed = 1'b0;
    dividend  = 32'd100;
    divisor   = 32'd7;
    tick();
    tick();
    check_val("reset_busy", 32'(busy), 32'd0);
    check_val("reset_done", 32'(done), 32'd0);
    check_val("reset_quotient", quotient, 32'd0);
    check_val("reset_remainder", remainder, 32'd0);
    start = 1'b0;
    reset = 1'b0;
    tick();
    check_val("idle_after_reset", 32'(busy), 32'd0);

    run_op(32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 1'b0);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b0);
    run_op(32'd5, 32'd0, 1'b0, 1'b1, 1'b0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
    run_op(32'd9, 32'd3, 1'b0, 1'b0, 1'b0);

    // Reset at edge 10 of an operation, new start sampled at edge 12.
    dividend  = 32'd1234567;
    divisor   = 32'd89;
    is_signed = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_done", 32'(done), 32'd0);
    check_val("abort_quotient", quotient, 32'd0);
    check_val("abort_remainder", remainder, 32'd0);
    reset = 1'b0;
    tick();
    check_val("abort_no_done", 32'(done), 32'd0);
    last_q = '0;
    last_r = '0;
    run_op(32'd1234567, 32'd89, 1'b1, 1'b0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      a = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2: begin
          a = 32'h8000_0000;
          b = 32'hFFFF_FFFF;
          s = 1'b1;
        end
        3:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      ch = (k < 39) && ($urandom_range(0, 3) == 0);
      run_op(a, b, s, 1'b0, ch);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_divider.md
# mips_divider

Multi-cycle 32-bit integer divider serving MIPS `div`/`divu`. It accepts a dividend/divisor pair on a single-cycle start strobe and runs a radix-2 restoring algorithm, one quotient bit per clock. It returns the quotient (LO) and remainder (HI) with a one-cycle done pulse. It sits beside the combinational ALU and feeds the HI/LO registers; the datapath stalls on `busy`.

## Interface
- `WIDTH`, 32: operand and result width; all counters and arithmetic derive from it.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle request; sampled only in IDLE or DONE.
- `is_signed`  in  1  1 = `div` (two's complement), 0 = `divu`; sampled with `start`.
- `dividend`  in  32  rs operand; sampled with `start`.
- `divisor`  in  32  rt operand; sampled with `start`.
- `busy`  out  1  high in CALC and SIGN.
- `done`  out  1  high exactly one cycle (DONE state).
- `quotient`  out  32  to LO; holds last result.
- `remainder`  out  32  to HI; holds last result.

## Operation
- States: IDLE, CALC, SIGN, DONE.
- IDLE --start--> CALC.
  - Latch |dividend| and |divisor| (magnitudes if `is_signed`, raw otherwise).
  - Latch the quotient sign (sign(dividend) XOR sign(divisor)) and the remainder sign (sign(dividend)).
  - Clear the 33-bit partial remainder; iteration counter = 0.
- CALC, per cycle:
  - Shift {partial remainder, dividend register} left 1.
  - Trial-subtract the divisor in 33 bits.
  - If non-negative, keep the difference and shift in quotient bit 1; else restore and shift in 0.
  - Counter increments; after the 32nd iteration, go to SIGN.
- SIGN: negate the quotient if its sign is set; negate the remainder if the dividend was negative. Write `quotient`/`remainder`. Go to DONE.
- DONE: `done` = 1. `start` here → CALC (back-to-back); else → IDLE.
- `start` in CALC/SIGN is ignored; it is not queued.
- Divisor 0 (either mode): the algorithm runs unchanged and takes full latency. Result: quotient = 0xFFFFFFFF, remainder = dividend (unsigned) or dividend with sign restored (signed). No exception is raised.
- Signed 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0. This is wrap-around from 32-bit magnitude arithmetic, not a special case.
- Remainder sign always follows the dividend; quotient truncates toward zero.
- `quotient`/`remainder` change only on the SIGN→DONE edge.

## Timing
- Reset: state = IDLE, `busy` = 0, `done` = 0, `quotient` = 0, `remainder` = 0, counter = 0. Reset dominates every other input on the same edge.
- Reset mid-operation: abort on the next edge. No `done` pulse; outputs return to 0.
- Latency, with `start` sampled at edge 0:
  - `busy` = 1 after edges 0–32.
  - SIGN runs between edges 32 and 33.
  - `done` = 1 and results are valid between edges 33 and 34.
- Throughput: one result per 34 cycles when restarting from DONE. The restarting `start` coincides with `done`.
- `busy` and `done` are never high together.

## Structure
- The shared definitions package holds:
  - `WIDTH` default,
  - the 2-bit state encodings (IDLE = 00, CALC = 01, SIGN = 10, DONE = 11),
  - the counter width (clog2(WIDTH)+1).
- Sub-module `div_step`: combinational single restoring iteration.
  - Inputs: 33-bit partial remainder, incoming dividend bit, divisor.
  - Outputs: next partial remainder, quotient bit.
  - Built from the existing adder and inverter cells.
- Top level holds the FSM, counter, operand registers, sign logic and output registers.

## Test plan
- Unsigned 100 / 7, `is_signed` = 0 → after edge 33: `done` = 1, quotient = 14, remainder = 2. `busy` high across edges 0–32.
- Signed −7 (0xFFFFFFF9) / 2 → quotient = 0xFFFFFFFD (−3), remainder = 0xFFFFFFFF (−1). Same inputs with `is_signed` = 0 → quotient = 0x7FFFFFFC, remainder = 1.
- Divide by zero, unsigned 5 / 0 → quotient = 0xFFFFFFFF, remainder = 5, `done` at edge 33.
- Signed 0x80000000 / 0xFFFFFFFF → quotient = 0x80000000, remainder = 0.
- Back-to-back and ignored starts:
  - Assert `start` during `done` with 9 / 3 → second result (quotient = 3, remainder = 0) at edge 67.
  - `start` pulses at edges 5 and 20 are ignored (no second `done`).
- `reset` at edge 10 of an operation → `busy` = 0 next cycle, `done` never pulses, outputs 0. A new `start` at edge 12 completes normally at edge 45.
